// File: rtl/wave_reader.sv
// Display-side capture RAM reader: reads one screen per channel around the trigger,
// scales each sample to a screen row and writes it into the LCD column buffer.
module wave_reader #(
    parameter int H_POINTS = 480,
    parameter int PRE_TRIG = 240,
    parameter int RD_LAT   = 2,
    parameter int Y_CENTER = 136,
    parameter int Y_MAX    = 271
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        display_en,
    output logic        display_done,
    input  logic [13:0] trig_pos,
    input  logic [13:0] h_offset,
    input  logic [7:0]  v_gain,
    output logic        read_enable,
    output logic [14:0] ram_data_addr,
    input  logic [7:0]  ram_data_out_a,
    input  logic [7:0]  ram_data_out_b,
    output logic        col_we,
    output logic [8:0]  col_addr,
    output logic [8:0]  col_y_a,
    output logic [8:0]  col_y_b,
    output logic        busy,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [8:0]         H_LAST     = 9'(H_POINTS - 1);
    localparam logic [8:0]         DRAIN_LAST = 9'(RD_LAT);
    localparam logic [13:0]        PRE_TRIG_W = 14'(PRE_TRIG);
    localparam logic signed [17:0] Y_CENTER_S = 18'(Y_CENTER);
    localparam logic signed [17:0] Y_MAX_S    = 18'(Y_MAX);

    state_t      state_q, state_d;
    logic [13:0] base_q, base_d;
    logic [7:0]  gain_q, gain_d;
    logic [8:0]  k_q, k_d;
    logic        abort;

    logic        en_s1_q, en_s_q, en_sd_q, armed_q;
    logic [1:0]  fill_q;
    logic        en_rise;

    logic [RD_LAT-1:0] vld_q;
    logic [8:0]        kp_q [RD_LAT];
    logic              col_we_q;
    logic [8:0]        col_addr_q, col_y_a_q, col_y_b_q;

    // armed_q only sets once the synchroniser holds real samples and shows the
    // request low, so a display_en already high across reset is never taken as new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1_q <= 1'b0;
            en_s_q  <= 1'b0;
            en_sd_q <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            en_s1_q <= display_en;
            en_s_q  <= en_s1_q;
            en_sd_q <= en_s_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_q | (fill_q[1] & ~en_s_q);
        end
    end

    assign en_rise = en_s_q & ~en_sd_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        gain_d  = gain_q;
        k_d     = k_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: if (en_rise && armed_q) state_d = LATCH;
            LATCH: begin
                if (!en_s_q) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    base_d  = trig_pos - PRE_TRIG_W + h_offset;
                    gain_d  = v_gain;
                    k_d     = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (!en_s_q) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (k_q == H_LAST) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 9'd1;
                end
            end
            DRAIN: begin
                if (!en_s_q) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (k_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 9'd1;
                end
            end
            DONE: if (!en_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            gain_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            gain_q  <= gain_d;
            k_q     <= k_d;
        end
    end

    // Y = Y_CENTER - ((sample - 128) * gain >>> 4), clamped to the screen.
    function automatic logic [8:0] scale(input logic [7:0] smp, input logic [7:0] gain);
        logic signed [8:0]  d;
        logic signed [17:0] p;
        logic signed [17:0] s;
        logic signed [17:0] y;
        d = $signed({1'b0, smp}) - 9'sd128;
        p = $signed({{9{d[8]}}, d}) * $signed({10'b0, gain});
        s = p >>> 4;
        y = Y_CENTER_S - s;
        if (y < 0)             return 9'd0;
        else if (y > Y_MAX_S)  return 9'(Y_MAX);
        else                   return y[8:0];
    endfunction

    // valid/k travel alongside the RAM read so data and column index line up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            for (int i = 0; i < RD_LAT; i++) kp_q[i] <= '0;
            col_we_q   <= 1'b0;
            col_addr_q <= '0;
            col_y_a_q  <= '0;
            col_y_b_q  <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                kp_q[i]  <= kp_q[i-1];
            end
            vld_q[0] <= read_enable;
            kp_q[0]  <= k_q;
            if (abort) vld_q <= '0;
            col_we_q <= vld_q[RD_LAT-1] & ~abort;
            if (vld_q[RD_LAT-1]) begin
                col_addr_q <= kp_q[RD_LAT-1];
                col_y_a_q  <= scale(ram_data_out_a, gain_q);
                col_y_b_q  <= scale(ram_data_out_b, gain_q);
            end
        end
    end

    assign read_enable   = (state_q == READ);
    assign ram_data_addr = {1'b0, base_q + 14'(k_q)};
    assign display_done  = (state_q == DONE) && en_s_q;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign col_we        = col_we_q;
    assign col_addr      = col_addr_q;
    assign col_y_a       = col_y_a_q;
    assign col_y_b       = col_y_b_q;
    assign dbg_state_o   = state_q;

endmodule
